// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared state type, defaults and helpers for the Wishbone arbiter.
// The ABORT state exists only when WB_ARB_TIMEOUT_EN is defined.
package wb_arb_pkg;

    localparam int DefTimeoutCycles = 1024;

`ifdef WB_ARB_TIMEOUT_EN
    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GRANT = 2'd1,
        ARB_ABORT = 2'd2
    } arb_state_t;
`else
    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;
`endif

    // Index width that stays legal for a single-master build.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wb_arb_rr_pick.sv
// wb_arb_rr_pick: combinational round-robin picker; returns a one-hot winner,
// searching from last_owner+1 upward (mod NrMasters).
module wb_arb_rr_pick
    import wb_arb_pkg::*;
#(
    parameter int NrMasters = 2,
    localparam int IdxW = idx_width(NrMasters)
) (
    input  logic [NrMasters-1:0] req,
    input  logic [IdxW-1:0]      last_owner,
    output logic [NrMasters-1:0] winner
);

    logic [IdxW-1:0] idx;

    // Walk from the farthest candidate to the nearest so the nearest requester wins.
    always_comb begin
        winner = '0;
        idx    = '0;
        for (int i = NrMasters; i >= 1; i--) begin
            idx = IdxW'((int'(last_owner) + i) % NrMasters);
            if (req[idx]) begin
                winner      = '0;
                winner[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: round-robin arbiter sharing one pipelined Wishbone slave among NrMasters.
// Define WB_ARB_TIMEOUT_EN to add a watchdog that aborts transfers to a hung slave.
//
//   state     | meaning
//   ARB_IDLE  | no owner; pick next requester round-robin
//   ARB_GRANT | owner routed to slave until it drops m_cyc
//   ARB_ABORT | watchdog tripped; slave cut off until owner drops m_cyc
module wb_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NrMasters     = 2,
    parameter int AddrWidth     = 32,
    parameter int DataWidth     = 32,
    parameter int TimeoutCycles = DefTimeoutCycles
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NrMasters-1:0]            m_cyc,
    input  logic [NrMasters-1:0]            m_stb,
    input  logic [NrMasters-1:0]            m_we,
    input  logic [NrMasters*AddrWidth-1:0]  m_adr,
    input  logic [NrMasters*DataWidth/8-1:0] m_sel,
    input  logic [NrMasters*DataWidth-1:0]  m_dat_w,
    output logic [DataWidth-1:0]            m_dat_r,
    output logic [NrMasters-1:0]            m_ack,
    output logic [NrMasters-1:0]            m_err,
    output logic [NrMasters-1:0]            m_stall,
    output logic                            s_cyc,
    output logic                            s_stb,
    output logic                            s_we,
    output logic [AddrWidth-1:0]            s_adr,
    output logic [DataWidth/8-1:0]          s_sel,
    output logic [DataWidth-1:0]            s_dat_w,
    input  logic [DataWidth-1:0]            s_dat_r,
    input  logic                            s_ack,
    input  logic                            s_err,
    input  logic                            s_stall,
    output logic [NrMasters-1:0]            grant
);

    localparam int IdxW     = idx_width(NrMasters);
    localparam int SelWidth = DataWidth / 8;

    arb_state_t           state;
    logic [IdxW-1:0]      last_owner;
    logic [IdxW-1:0]      owner;
    logic [NrMasters-1:0] winner;
    logic                 owner_cyc;
    logic                 active;
    logic                 wd_trip;

    wb_arb_rr_pick #(
        .NrMasters(NrMasters)
    ) u_pick (
        .req        (m_cyc),
        .last_owner (last_owner),
        .winner     (winner)
    );

    always_comb begin
        owner = '0;
        for (int i = 0; i < NrMasters; i++) begin
            if (grant[i]) owner = IdxW'(i);
        end
    end

    assign owner_cyc = m_cyc[owner];
    assign active    = (state == ARB_GRANT);

`ifdef WB_ARB_TIMEOUT_EN
    localparam int WdW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
    logic [WdW-1:0] wd_count;

    assign wd_trip = active && owner_cyc && !s_ack && !s_err &&
                     (wd_count == WdW'(TimeoutCycles - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_count <= '0;
        end else if (active && owner_cyc && !wd_trip && !s_ack && !s_err) begin
            wd_count <= wd_count + 1'b1;
        end else begin
            wd_count <= '0;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TimeoutCycles > 0);
    assign wd_trip        = 1'b0;
`endif

    always_comb begin
        s_cyc   = 1'b0;
        s_stb   = 1'b0;
        s_we    = 1'b0;
        s_adr   = m_adr[owner*AddrWidth +: AddrWidth];
        s_sel   = m_sel[owner*SelWidth +: SelWidth];
        s_dat_w = m_dat_w[owner*DataWidth +: DataWidth];
        m_ack   = '0;
        m_err   = '0;
        m_stall = '1;
        if (active) begin
            if (wd_trip) begin
                m_err[owner] = 1'b1;
            end else begin
                s_cyc          = owner_cyc;
                s_stb          = owner_cyc && m_stb[owner];
                s_we           = m_we[owner];
                m_ack[owner]   = s_ack;
                m_err[owner]   = s_err;
                m_stall[owner] = s_stall;
            end
        end
    end

    assign m_dat_r = s_dat_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ARB_IDLE;
            grant      <= '0;
            last_owner <= IdxW'(NrMasters - 1);
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (|m_cyc) begin
                        grant <= winner;
                        state <= ARB_GRANT;
                    end
                end
                ARB_GRANT: begin
                    if (!owner_cyc) begin
                        last_owner <= owner;
                        grant      <= '0;
                        state      <= ARB_IDLE;
                    end
`ifdef WB_ARB_TIMEOUT_EN
                    else if (wd_trip) begin
                        state <= ARB_ABORT;
                    end
`endif
                end
`ifdef WB_ARB_TIMEOUT_EN
                ARB_ABORT: begin
                    if (!owner_cyc) begin
                        last_owner <= owner;
                        grant      <= '0;
                        state      <= ARB_IDLE;
                    end
                end
`endif
                default: begin
                    grant <= '0;
                    state <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed scenarios with literal expectations plus a randomized
// phase, all checked every cycle against an owner-tracking arbitration model.
module tb_wb_arbiter;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    m_cyc, m_stb, m_we;
    logic [N*AW-1:0] m_adr;
    logic [N*SW-1:0] m_sel;
    logic [N*DW-1:0] m_dat_w;
    logic [DW-1:0]   m_dat_r;
    logic [N-1:0]    m_ack, m_err, m_stall;
    logic            s_cyc, s_stb, s_we;
    logic [AW-1:0]   s_adr;
    logic [SW-1:0]   s_sel;
    logic [DW-1:0]   s_dat_w, s_dat_r;
    logic            s_ack, s_err, s_stall;
    logic [N-1:0]    grant;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    wb_arbiter #(
        .NrMasters(N), .AddrWidth(AW), .DataWidth(DW), .TimeoutCycles(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr), .m_sel(m_sel),
        .m_dat_w(m_dat_w), .m_dat_r(m_dat_r), .m_ack(m_ack), .m_err(m_err),
        .m_stall(m_stall), .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr),
        .s_sel(s_sel), .s_dat_w(s_dat_w), .s_dat_r(s_dat_r), .s_ack(s_ack),
        .s_err(s_err), .s_stall(s_stall), .grant(grant)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: who owns the bus (-1 = nobody), whether it is aborting, who owned last.
    int m_owner = -1;
    int m_last  = N - 1;
    int m_wd    = 0;
    bit m_abort = 1'b0;

    always @(negedge clk) begin : cmp
        logic [N-1:0] e_grant, e_ack, e_err, e_stall;
        logic         e_cyc, e_stb;
        bit           ing, trip;
        if (rst) begin
            m_owner = -1; m_last = N - 1; m_wd = 0; m_abort = 1'b0;
        end
        ing  = (m_owner >= 0) && !m_abort;
        trip = 1'b0;
`ifdef WB_ARB_TIMEOUT_EN
        trip = ing && m_cyc[m_owner] && !s_ack && !s_err && (m_wd == TO - 1);
`endif
        e_grant = '0; e_ack = '0; e_err = '0; e_stall = '1; e_cyc = 1'b0; e_stb = 1'b0;
        if (m_owner >= 0) e_grant[m_owner] = 1'b1;
        if (ing && trip) e_err[m_owner] = 1'b1;
        if (ing && !trip) begin
            e_cyc = m_cyc[m_owner];
            e_stb = m_cyc[m_owner] && m_stb[m_owner];
            e_ack[m_owner]   = s_ack;
            e_err[m_owner]   = s_err;
            e_stall[m_owner] = s_stall;
        end
        chk("grant", grant, e_grant);
        chk("s_cyc", s_cyc, e_cyc);
        chk("s_stb", s_stb, e_stb);
        chk("m_ack", m_ack, e_ack);
        chk("m_err", m_err, e_err);
        chk("m_stall", m_stall, e_stall);
        chk("m_dat_r", m_dat_r, s_dat_r);
        if (e_cyc) begin
            chk("s_we", s_we, m_we[m_owner]);
            chk("s_adr", s_adr, m_adr[m_owner*AW +: AW]);
            chk("s_sel", s_sel, m_sel[m_owner*SW +: SW]);
            chk("s_dat_w", s_dat_w, m_dat_w[m_owner*DW +: DW]);
        end
        if (!rst) begin
            if (m_owner < 0) begin
                for (int k = 1; k <= N; k++)
                    if (m_owner < 0 && m_cyc[(m_last + k) % N]) m_owner = (m_last + k) % N;
                m_wd = 0;
            end else if (!m_cyc[m_owner]) begin
                m_last = m_owner; m_owner = -1; m_abort = 1'b0; m_wd = 0;
            end else if (trip) begin
                m_abort = 1'b1; m_wd = 0;
            end else if (!m_abort) begin
                m_wd = (s_ack || s_err) ? 0 : m_wd + 1;
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic go_idle(input int n);
        m_cyc = '0; m_stb = '0; m_we = '0; s_ack = 1'b0; s_err = 1'b0; s_stall = 1'b0;
        repeat (n) step();
    endtask

    task automatic rand_phase(input int cycles);
        int   to_issue[N];
        int   outst[N];
        bit   act[N];
        bit   acc_m[N], resp_m[N], err_m[N];
        bit   s_acc, s_cyc_s, s_resp;
        int   sq[$];
        for (int i = 0; i < N; i++) begin to_issue[i] = 0; outst[i] = 0; act[i] = 1'b0; end
        repeat (cycles) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                acc_m[i]  = m_cyc[i] && m_stb[i] && !m_stall[i];
                resp_m[i] = m_ack[i];
                err_m[i]  = m_err[i];
            end
            s_acc   = s_cyc && s_stb && !s_stall;
            s_cyc_s = s_cyc;
            s_resp  = s_ack || s_err;
            step();
            if (!s_cyc_s) begin
                sq.delete();
            end else begin
                if (s_resp && sq.size() > 0) void'(sq.pop_front());
                foreach (sq[k]) if (sq[k] > 0) sq[k]--;
                if (s_acc) sq.push_back(int'($urandom_range(0, 3)));
            end
            s_ack = 1'b0; s_err = 1'b0;
            if (sq.size() > 0 && sq[0] == 0) begin
                if ($urandom_range(0, 15) == 0) s_err = 1'b1; else s_ack = 1'b1;
            end
            s_stall = ($urandom_range(0, 3) == 0);
            s_dat_r = $urandom;
            for (int i = 0; i < N; i++) begin
                if (act[i]) begin
                    if (err_m[i]) begin
                        act[i] = 1'b0; to_issue[i] = 0; outst[i] = 0;
                    end else begin
                        if (acc_m[i]) begin to_issue[i]--; outst[i]++; end
                        if (resp_m[i] && outst[i] > 0) outst[i]--;
                        if (to_issue[i] == 0 && outst[i] == 0) act[i] = 1'b0;
                    end
                end else if ($urandom_range(0, 2) == 0) begin
                    act[i] = 1'b1; to_issue[i] = int'($urandom_range(1, 4)); outst[i] = 0;
                end
                m_cyc[i] = act[i];
                m_stb[i] = act[i] && (to_issue[i] > 0);
                m_we[i]  = 1'($urandom);
                m_adr[i*AW +: AW]   = $urandom;
                m_sel[i*SW +: SW]   = SW'($urandom);
                m_dat_w[i*DW +: DW] = $urandom;
            end
        end
    endtask

    initial begin
        logic [N-1:0] seq[6];
        logic [N-1:0] prev, done;
        int           n;
        rst = 1'b1;
        m_cyc = '0; m_stb = '0; m_we = '0;
        m_adr = {32'h0000_1000, 32'h0000_0100};
        m_sel = {4'hc, 4'h3};
        m_dat_w = {32'hbbbb_0001, 32'haaaa_0001};
        s_dat_r = 32'h1234_5678; s_ack = 1'b0; s_err = 1'b0; s_stall = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_grant", grant, 2'b00);
        chk("rst_s_cyc", s_cyc, 1'b0);
        chk("rst_stall", m_stall, 2'b11);

        // Simultaneous requests: master 0 first, one idle cycle, then master 1.
        step(); m_cyc = 2'b11; m_stb = 2'b11;
        step();
        @(negedge clk);
        chk("r030_grant0", grant, 2'b01);
        chk("r030_s_cyc", s_cyc, 1'b1);
        chk("r030_adr", s_adr, 32'h0000_0100);
        step(); m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
        step();
        @(negedge clk);
        chk("r030_idle", grant, 2'b00);
        step();
        @(negedge clk);
        chk("r030_grant1", grant, 2'b10);
        chk("r030_sel", s_sel, 4'hc);
        go_idle(2);

        // Four pipelined reads from master 0, acks three cycles behind.
        m_cyc = 2'b11; m_stb = 2'b11;
        for (int c = 1; c <= 10; c++) begin
            step();
            m_stb[0] = (c <= 4);
            s_ack    = (c >= 4 && c <= 7);
            m_cyc[0] = (c <= 7);
            @(negedge clk);
            if (c <= 8) begin
                chk("r031_grant", grant, 2'b01);
                chk("r031_stall1", m_stall[1], 1'b1);
            end
            if (c >= 4 && c <= 7) chk("r031_ack0", m_ack[0], 1'b1);
            if (c == 9) chk("r031_idle", grant, 2'b00);
            if (c == 10) chk("r031_next", grant, 2'b10);
        end
        go_idle(3);

        // Both keep requesting single transfers: grants must alternate.
        s_ack = 1'b1; m_cyc = 2'b11; m_stb = 2'b11; n = 0; prev = '0;
        for (int c = 0; c < 40 && n < 6; c++) begin
            @(negedge clk);
            if (grant != 0 && prev == 0) begin seq[n] = grant; n++; end
            prev = grant;
            done = m_ack & m_cyc;
            step();
            m_cyc = ~done; m_stb = ~done;
        end
        chk("r032_count", n, 6);
        for (int k = 0; k < 6; k++) chk("r032_seq", seq[k], (k % 2 == 0) ? 2'b01 : 2'b10);
        go_idle(3);

        // Reset mid-transfer drops the slave cycle at once.
        m_cyc = 2'b10; m_stb = 2'b10;
        step();
        @(negedge clk);
        chk("r033_pre_grant", grant, 2'b10);
        chk("r033_pre_cyc", s_cyc, 1'b1);
        step(); rst = 1'b1; #1;
        chk("r033_cyc", s_cyc, 1'b0);
        chk("r033_grant", grant, 2'b00);
        step(); rst = 1'b0; m_cyc = 2'b11; m_stb = 2'b11;
        step();
        @(negedge clk);
        chk("r033_after", grant, 2'b01);
        go_idle(3);

        // Slave error on the first write cycle.
        m_cyc = 2'b01; m_stb = 2'b01; m_we = 2'b01; s_err = 1'b1;
        step();
        @(negedge clk);
        chk("r035_err", m_err, 2'b01);
        chk("r035_we", s_we, 1'b1);
        chk("r035_ack", m_ack, 2'b00);
        step(); m_cyc = '0; m_stb = '0; m_we = '0; s_err = 1'b0;
        @(negedge clk);
        chk("r035_hold", grant, 2'b01);
        step();
        @(negedge clk);
        chk("r035_rel", grant, 2'b00);
        go_idle(2);

`ifdef WB_ARB_TIMEOUT_EN
        // Hung slave: error pulse on the cycle the watchdog reaches TO-1.
        m_cyc = 2'b01; m_stb = 2'b01;
        for (int c = 1; c <= 12; c++) begin
            step();
            if (c == 11) begin m_cyc = '0; m_stb = '0; end
            @(negedge clk);
            if (c <= 10) chk("r034_grant", grant, 2'b01);
            if (c < TO) chk("r034_noerr", m_err[0], 1'b0);
            if (c == TO) begin
                chk("r034_err", m_err[0], 1'b1);
                chk("r034_cut", s_cyc, 1'b0);
            end
            if (c > TO && c <= 10) begin
                chk("r034_abort_cyc", s_cyc, 1'b0);
                chk("r034_abort_stall", m_stall[0], 1'b1);
                chk("r034_abort_err", m_err[0], 1'b0);
            end
            if (c == 12) chk("r034_idle", grant, 2'b00);
        end
        go_idle(2);
`endif

        rand_phase(4000);
        go_idle(4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
